// File: rtl/l1_mem_arbiter.sv
// l1_mem_arbiter: shares the physical-memory line port between I-cache and
// D-cache. D wins ties; a starvation counter forces an I grant after
// STARVE_LIMIT consecutive D grants taken while I was waiting. One line
// transaction in flight; every output comes straight from a register.
module l1_mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int LINE_W       = 256,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY, RESP} state_e;

  localparam logic [3:0]        LIMIT     = 4'(STARVE_LIMIT);
  // 32-byte lines: the low five address bits never reach memory
  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(32'h1f);

  state_e            state_q, state_d;
  logic [3:0]        starve_q, starve_d;
  logic              rd_q, rd_d, wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;
  logic [LINE_W-1:0] i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
  logic              i_resp_q, i_resp_d, d_resp_q, d_resp_d;
  logic              d_req, force_i;

  // Next-state: arbitration in IDLE, wait for memory in *_BUSY, one resp cycle
  always_comb begin
    state_d   = state_q;
    starve_d  = starve_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    i_resp_d  = 1'b0;
    d_resp_d  = 1'b0;
    d_req     = d_read | d_write;
    force_i   = i_read && (starve_q == LIMIT);
    case (state_q)
      IDLE: begin
        if (d_req && !force_i) begin
          state_d = D_BUSY;
          // read+write together is a write-back; the read is retried later
          wr_d    = d_write;
          rd_d    = ~d_write;
          addr_d  = d_address & LINE_MASK;
          if (d_write) wdata_d = d_wdata;
          if (!i_read)              starve_d = '0;
          else if (starve_q != LIMIT) starve_d = starve_q + 4'd1;
        end else if (i_read) begin
          state_d  = I_BUSY;
          rd_d     = 1'b1;
          wr_d     = 1'b0;
          addr_d   = i_address & LINE_MASK;
          starve_d = '0;
        end
      end
      I_BUSY, D_BUSY: begin
        if (pmem_resp) begin
          state_d = RESP;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          if (state_q == I_BUSY) begin
            i_resp_d  = 1'b1;
            i_rdata_d = pmem_rdata;
          end else begin
            d_resp_d = 1'b1;
            // a write-back returns no data; keep the last read line
            if (rd_q) d_rdata_d = pmem_rdata;
          end
        end
      end
      // the cache still shows its old request here, so nothing is sampled
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; synchronous active-low reset aborts everything
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      starve_q  <= '0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      i_resp_q  <= 1'b0;
      d_resp_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      starve_q  <= starve_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      i_resp_q  <= i_resp_d;
      d_resp_q  <= d_resp_d;
    end
  end

  assign pmem_read    = rd_q;
  assign pmem_write   = wr_q;
  assign pmem_address = addr_q;
  assign pmem_wdata   = wdata_q;
  assign i_rdata      = i_rdata_q;
  assign i_resp       = i_resp_q;
  assign d_rdata      = d_rdata_q;
  assign d_resp       = d_resp_q;

endmodule

// File: tb/tb_l1_mem_arbiter.sv
// Bench for l1_mem_arbiter: directed scenarios plus a randomized run scored
// against a transaction-level model of the arbitration rules.
module tb_l1_mem_arbiter;
  localparam int ADDR_W = 32;
  localparam int LINE_W = 256;
  localparam int LIM    = 4;

  logic              clk = 1'b0, rst = 1'b0;
  logic              i_read = 1'b0, d_read = 1'b0, d_write = 1'b0, pmem_resp = 1'b0;
  logic [ADDR_W-1:0] i_address = '0, d_address = '0;
  logic [LINE_W-1:0] d_wdata = '0, pmem_rdata = '0;
  logic [LINE_W-1:0] i_rdata, d_rdata, pmem_wdata;
  logic              i_resp, d_resp, pmem_read, pmem_write;
  logic [ADDR_W-1:0] pmem_address;

  int vecs = 0, errs = 0;
  logic [LINE_W-1:0] m_irdata = '0, m_drdata = '0;

  always #5 clk = ~clk;

  l1_mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] r;
    for (int k = 0; k < LINE_W/32; k++) r[k*32 +: 32] = $urandom();
    return r;
  endfunction

  task automatic do_reset();
    rst = 1'b0; i_read = 0; d_read = 0; d_write = 0; pmem_resp = 0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    m_irdata = '0; m_drdata = '0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      vecs++;
      if ((i_resp | d_resp | pmem_read | pmem_write | (|pmem_address) | (|pmem_wdata)
           | (|i_rdata) | (|d_rdata)) !== 1'b0) begin
        errs++;
        $display("FAIL reset_idle cycle=%0d rd=%b wr=%b ir=%b dr=%b addr=%h", c, pmem_read,
                 pmem_write, i_resp, d_resp, pmem_address);
      end
    end
  endtask

  task automatic test_i_read();
    logic [LINE_W-1:0] a5;
    a5 = {32{8'hA5}};
    @(negedge clk); i_read = 1; i_address = 32'h0000_1234;
    @(negedge clk);
    vecs++; if (pmem_read !== 1'b1 || pmem_write !== 1'b0) begin errs++;
      $display("FAIL iread_strobe rd=%b wr=%b exp rd=1 wr=0", pmem_read, pmem_write); end
    vecs++; if (pmem_address !== 32'h0000_1220) begin errs++;
      $display("FAIL iread_addr got=%h exp=00001220", pmem_address); end
    for (int c = 2; c <= 5; c++) begin
      @(negedge clk);
      vecs++; if (pmem_read !== 1'b1 || pmem_address !== 32'h0000_1220) begin errs++;
        $display("FAIL iread_hold cycle=%0d rd=%b addr=%h", c, pmem_read, pmem_address); end
    end
    pmem_resp = 1; pmem_rdata = a5;
    @(negedge clk); pmem_resp = 0;
    vecs++; if (i_resp !== 1'b1 || d_resp !== 1'b0 || pmem_read !== 1'b0) begin errs++;
      $display("FAIL iread_resp ir=%b dr=%b rd=%b exp 1 0 0", i_resp, d_resp, pmem_read); end
    vecs++; if (i_rdata !== a5) begin errs++; $display("FAIL iread_data got=%h exp=%h", i_rdata, a5); end
    m_irdata = a5;
    @(negedge clk); i_read = 0;
    vecs++; if (i_resp !== 1'b0 || d_resp !== 1'b0) begin errs++;
      $display("FAIL iread_pulse ir=%b dr=%b exp 0 0", i_resp, d_resp); end
  endtask

  task automatic test_priority();
    logic [LINE_W-1:0] l1, l2;
    l1 = rand_line(); l2 = rand_line();
    @(negedge clk); d_read = 1; d_address = 32'h0000_2008; i_read = 1; i_address = 32'h0000_3010;
    @(negedge clk);
    vecs++; if (pmem_read !== 1'b1 || pmem_address !== 32'h0000_2000) begin errs++;
      $display("FAIL prio_first rd=%b addr=%h exp 1 00002000", pmem_read, pmem_address); end
    vecs++; if (dut.starve_q !== 4'd1) begin errs++;
      $display("FAIL prio_starve1 got=%0d exp=1", dut.starve_q); end
    pmem_resp = 1; pmem_rdata = l1;
    @(negedge clk); pmem_resp = 0;
    vecs++; if (d_resp !== 1'b1 || i_resp !== 1'b0 || d_rdata !== l1) begin errs++;
      $display("FAIL prio_dresp dr=%b ir=%b data_ok=%b", d_resp, i_resp, d_rdata === l1); end
    m_drdata = l1;
    @(negedge clk); d_read = 0;
    @(negedge clk);
    vecs++; if (pmem_read !== 1'b1 || pmem_address !== 32'h0000_3000) begin errs++;
      $display("FAIL prio_second rd=%b addr=%h exp 1 00003000", pmem_read, pmem_address); end
    vecs++; if (dut.starve_q !== 4'd0) begin errs++;
      $display("FAIL prio_starve0 got=%0d exp=0", dut.starve_q); end
    pmem_resp = 1; pmem_rdata = l2;
    @(negedge clk); pmem_resp = 0;
    vecs++; if (i_resp !== 1'b1 || d_resp !== 1'b0 || i_rdata !== l2) begin errs++;
      $display("FAIL prio_iresp ir=%b dr=%b data_ok=%b", i_resp, d_resp, i_rdata === l2); end
    m_irdata = l2;
    @(negedge clk); i_read = 0;
  endtask

  task automatic test_starvation();
    logic [LINE_W-1:0] ld;
    int t;
    bit got_d;
    @(negedge clk); i_read = 1; i_address = 32'h0000_7000; d_read = 1; d_address = 32'h0000_4000;
    for (int g = 0; g < 6; g++) begin
      t = 0;
      @(negedge clk);
      while (!pmem_read && t < 20) begin @(negedge clk); t++; end
      vecs++; if (t >= 20) begin errs++; $display("FAIL starve_timeout grant=%0d got=none exp=grant", g); end
      got_d = (pmem_address !== 32'h0000_7000);
      vecs++; if (got_d !== (g != 4)) begin errs++;
        $display("FAIL starve_order grant=%0d got_d=%0b exp_d=%0b", g, got_d, g != 4); end
      ld = rand_line(); pmem_resp = 1; pmem_rdata = ld;
      @(negedge clk); pmem_resp = 0;
      vecs++; if ({i_resp, d_resp} !== (got_d ? 2'b01 : 2'b10)) begin errs++;
        $display("FAIL starve_resp grant=%0d ir=%b dr=%b", g, i_resp, d_resp); end
      if (got_d) m_drdata = ld; else m_irdata = ld;
      @(negedge clk);
      if (!got_d) i_read = 0;
      else d_address = 32'h0000_4000 + 32'((g + 1) * 64);
      if (g == 5) d_read = 0;
    end
  endtask

  task automatic test_write();
    logic [LINE_W-1:0] w, junk;
    w = {8{32'hDEAD_BEEF}};
    junk = ~m_drdata;
    @(negedge clk); d_write = 1; d_address = 32'h8000_0040; d_wdata = w;
    @(negedge clk);
    vecs++; if (pmem_write !== 1'b1 || pmem_read !== 1'b0) begin errs++;
      $display("FAIL write_strobe wr=%b rd=%b exp 1 0", pmem_write, pmem_read); end
    vecs++; if (pmem_address !== 32'h8000_0040 || pmem_wdata !== w) begin errs++;
      $display("FAIL write_addr_data addr=%h exp=80000040 wdata_ok=%b", pmem_address, pmem_wdata === w); end
    @(negedge clk);
    vecs++; if (pmem_write !== 1'b1 || pmem_read !== 1'b0) begin errs++;
      $display("FAIL write_hold wr=%b rd=%b", pmem_write, pmem_read); end
    pmem_resp = 1; pmem_rdata = junk;
    @(negedge clk); pmem_resp = 0;
    vecs++; if (d_resp !== 1'b1 || i_resp !== 1'b0 || pmem_read !== 1'b0 || pmem_write !== 1'b0) begin
      errs++; $display("FAIL write_resp dr=%b ir=%b rd=%b wr=%b", d_resp, i_resp, pmem_read, pmem_write); end
    vecs++; if (d_rdata !== m_drdata) begin errs++;
      $display("FAIL write_rdata_kept got=%h exp=%h", d_rdata[31:0], m_drdata[31:0]); end
    @(negedge clk); d_write = 0;
  endtask

  task automatic test_reset_mid();
    @(negedge clk); d_write = 1; d_address = 32'h9000_0085; d_wdata = rand_line();
    @(negedge clk);
    vecs++; if (pmem_write !== 1'b1) begin errs++; $display("FAIL rstmid_grant wr=%b exp=1", pmem_write); end
    rst = 0;
    @(negedge clk); rst = 1;
    m_drdata = '0; m_irdata = '0;
    vecs++; if (pmem_write !== 1'b0 || d_resp !== 1'b0 || d_rdata !== '0) begin errs++;
      $display("FAIL rstmid_abort wr=%b dr=%b rdata_zero=%b", pmem_write, d_resp, d_rdata === '0); end
    @(negedge clk);
    vecs++; if (pmem_write !== 1'b1 || pmem_address !== 32'h9000_0080 || d_resp !== 1'b0) begin errs++;
      $display("FAIL rstmid_regrant wr=%b addr=%h dr=%b", pmem_write, pmem_address, d_resp); end
    vecs++; if (dut.starve_q !== 4'd0) begin errs++;
      $display("FAIL rstmid_starve got=%0d exp=0", dut.starve_q); end
    pmem_resp = 1;
    @(negedge clk); pmem_resp = 0;
    vecs++; if (d_resp !== 1'b1) begin errs++; $display("FAIL rstmid_resp dr=%b exp=1", d_resp); end
    @(negedge clk); d_write = 0;
  endtask

  // Model: each cache holds its request until its resp, drops it after the
  // stale cycle and may re-request at once. Whenever the arbiter is free, the
  // winner follows the priority/starvation rule and its strobe appears next cycle.
  task automatic test_random(int ncyc);
    bit ir = 0, dr = 0, dw = 0, i_done = 0, d_done = 0;
    bit idle = 1, exp_gnt = 0, busy = 0, resp_due = 0, was_resp = 0, ex_d = 0, ex_w = 0;
    bit s_ir = 0, s_dr = 0, s_dw = 0;
    int starve = 0, lat = 0;
    logic [ADDR_W-1:0] ia = '0, da = '0, s_ia = '0, s_da = '0, ex_a = '0;
    logic [LINE_W-1:0] dwd = '0, s_dwd = '0, ex_wd = '0, rdat = '0;
    do_reset();
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      pmem_resp = 0;
      vecs++; if (pmem_read && pmem_write) begin errs++; $display("FAIL rnd_both_strobes cycle=%0d", c); end
      if (resp_due) begin
        vecs++; if ({i_resp, d_resp} !== (ex_d ? 2'b01 : 2'b10)) begin errs++;
          $display("FAIL rnd_resp cycle=%0d ir=%b dr=%b exp_d=%0b", c, i_resp, d_resp, ex_d); end
        if (!ex_d) m_irdata = rdat; else if (!ex_w) m_drdata = rdat;
        if (ex_d) d_done = 1; else i_done = 1;
        resp_due = 0; was_resp = 1;
      end else begin
        vecs++; if ((i_resp | d_resp) !== 1'b0) begin errs++;
          $display("FAIL rnd_spurious_resp cycle=%0d ir=%b dr=%b", c, i_resp, d_resp); end
      end
      vecs++; if (i_rdata !== m_irdata || d_rdata !== m_drdata) begin errs++;
        $display("FAIL rnd_rdata cycle=%0d i_ok=%b d_ok=%b", c, i_rdata === m_irdata, d_rdata === m_drdata); end
      if (exp_gnt) begin
        exp_gnt = 0;
        ex_d  = (s_dr | s_dw) && !(s_ir && starve == LIM);
        ex_w  = ex_d && s_dw;
        ex_a  = (ex_d ? s_da : s_ia) & ~32'h1f;
        ex_wd = s_dwd;
        if (!ex_d || !s_ir) starve = 0;
        else if (starve < LIM) starve++;
        busy = 1; lat = $urandom_range(0, 4);
      end
      if (busy) begin
        vecs++; if (pmem_read !== !ex_w || pmem_write !== ex_w || pmem_address !== ex_a) begin errs++;
          $display("FAIL rnd_busy cycle=%0d rd=%b wr=%b addr=%h exp_w=%0b exp_addr=%h", c, pmem_read,
                   pmem_write, pmem_address, ex_w, ex_a); end
        if (ex_w) begin
          vecs++; if (pmem_wdata !== ex_wd) begin errs++; $display("FAIL rnd_wdata cycle=%0d got=%h exp=%h",
            c, pmem_wdata[31:0], ex_wd[31:0]); end
        end
        if (lat == 0) begin
          rdat = rand_line(); pmem_rdata = rdat; pmem_resp = 1; busy = 0; resp_due = 1;
        end else lat--;
      end else begin
        vecs++; if ((pmem_read | pmem_write) !== 1'b0) begin errs++;
          $display("FAIL rnd_idle_strobe cycle=%0d rd=%b wr=%b", c, pmem_read, pmem_write); end
      end
      if (idle) begin
        if (i_done) begin ir = 0; i_done = 0; end
        if (d_done) begin dr = 0; dw = 0; d_done = 0; end
      end
      if (!ir && !i_done && $urandom_range(0, 2) == 0) begin ir = 1; ia = $urandom(); end
      if (!(dr | dw) && !d_done && $urandom_range(0, 2) == 0) begin
        case ($urandom_range(0, 2))
          0: begin dr = 1; dw = 0; end
          1: begin dr = 0; dw = 1; end
          default: begin dr = 1; dw = 1; end
        endcase
        da = $urandom(); dwd = rand_line();
      end
      i_read = ir; i_address = ia; d_read = dr; d_write = dw; d_address = da; d_wdata = dwd;
      if (idle) begin
        s_ir = ir; s_dr = dr; s_dw = dw; s_ia = ia; s_da = da; s_dwd = dwd;
        exp_gnt = ir | dr | dw;
        if (exp_gnt) idle = 0;
      end
      if (was_resp) begin idle = 1; was_resp = 0; end
    end
    i_read = 0; d_read = 0; d_write = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_i_read();
    test_priority();
    test_starvation();
    test_write();
    test_reset_mid();
    test_random(3000);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/l1_mem_arbiter.md
Name: l1_mem_arbiter

Overview:
- Shares the single physical-memory line port between the I-cache (read-only) and the D-cache (read/write) of the RV32I pipeline.
- Sits between the two L1 caches and the cacheline adaptor.
- D-cache has priority; a starvation counter guarantees the I-cache forward progress.
- One line transaction is in flight at a time; all memory-side outputs are registered.

Parameters:
- ADDR_W, 32, byte address width.
- LINE_W, 256, cache line width in bits (32-byte lines).
- STARVE_LIMIT, 4, consecutive D grants allowed while an I request waits before I is forced (legal range 1–15).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-low reset.
- i_read  in  1  I-cache line read request, level, held until i_resp.
- i_address  in  ADDR_W  I-cache line address.
- i_rdata  out  LINE_W  line returned to I-cache, valid when i_resp.
- i_resp  out  1  one-cycle completion pulse to I-cache.
- d_read  in  1  D-cache line read request, level.
- d_write  in  1  D-cache line write-back request, level.
- d_address  in  ADDR_W  D-cache line address.
- d_wdata  in  LINE_W  write-back line.
- d_rdata  out  LINE_W  line returned to D-cache, valid when d_resp.
- d_resp  out  1  one-cycle completion pulse to D-cache.
- pmem_read  out  1  line read to adaptor, held until pmem_resp.
- pmem_write  out  1  line write to adaptor, held until pmem_resp.
- pmem_address  out  ADDR_W  line-aligned address; bits [4:0] forced to 0.
- pmem_wdata  out  LINE_W  write line.
- pmem_rdata  in  LINE_W  read line from adaptor.
- pmem_resp  in  1  adaptor completion pulse.

Behaviour:
- Reset (rst==0 at an edge): state=IDLE, starve_cnt=0. All outputs 0, including rdata buses.
- Reset mid-transaction aborts the transaction and drops pmem_read/pmem_write in the next cycle. No resp is issued for the aborted transaction.
- States: IDLE, I_BUSY, D_BUSY, RESP.
- IDLE: sample requests. D request = d_read|d_write.
  - Grant D if D request and not (i_read && starve_cnt==STARVE_LIMIT).
  - Otherwise grant I if i_read.
  - Otherwise stay in IDLE.
- On grant, latch the address (low 5 bits zeroed), the op, and d_wdata (D write).
  - Next cycle: pmem_read or pmem_write =1 in I_BUSY or D_BUSY.
  - Latency: request visible at edge t gives pmem strobe high from cycle t+1.
- d_read and d_write both high: treated as a write. The same rule applies until resp.
- Starvation counter:
  - A D grant while i_read=1 increments starve_cnt, saturating at STARVE_LIMIT.
  - An I grant clears starve_cnt.
  - A D grant with i_read=0 clears starve_cnt.
- I_BUSY/D_BUSY: hold pmem strobe, address and wdata stable until pmem_resp.
  - On pmem_resp, register pmem_rdata into the granted side's rdata, deassert the pmem strobe, go to RESP.
- RESP: assert the granted side's *_resp for exactly one cycle; rdata is valid this cycle.
  - Requests are ignored in RESP, because the cache still shows the stale request this cycle.
  - Next state is IDLE.
- The ungranted side's resp stays 0 throughout. Its rdata holds its last value.
- rdata registers hold until the next completion for that side.
- Throughput: the minimum cycles per transaction is 3 + memory latency (grant, busy≥1, RESP). Back-to-back grants are separated by at least one IDLE cycle.
- pmem_read and pmem_write are never high together.
- A request dropped by a cache before resp (protocol violation) has no defined outcome; the arbiter still completes the transaction.

Test Plan:
- Reset hold then release, no requests → all outputs 0, state IDLE for 10 cycles.
- i_read=1, i_address=0x0000_1234, memory resp after 5 cycles with pmem_rdata=A5..A5 →
  - pmem_read rises one cycle after the request.
  - pmem_address=0x0000_1220.
  - i_resp pulses 1 cycle after pmem_resp with i_rdata=A5..A5.
  - d_resp stays 0.
- d_read and i_read asserted the same cycle → D served first, then I. starve_cnt goes 1 then 0. i_resp arrives after d_resp.
- STARVE_LIMIT=4, i_read held, D re-requests immediately after every d_resp → exactly 4 D grants, then an I grant, then D resumes.
- d_write=1 with d_wdata=0xDEAD…BEEF, d_address=0x8000_0040 →
  - pmem_write=1 with matching wdata and address.
  - pmem_read=0 throughout.
  - d_resp pulse; d_rdata unchanged.
- rst=0 for one cycle during D_BUSY →
  - pmem_write drops the next cycle.
  - No d_resp.
  - After release, a held d_write is regranted from IDLE with starve_cnt=0.
